// File: rtl/keypad_lock_pkg.sv
// Shared state encoding and counter-width helper for the keypad lock controller.
package keypad_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_e;

  // Bits needed to hold values 0..max_val inclusive (never less than one).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; o_expired_c is high whenever the count has reached zero.
module lock_timer
  import keypad_lock_pkg::*;
#(
  parameter  int unsigned MAX_VAL = 1000,
  localparam int unsigned W       = cnt_w(MAX_VAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired_c
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired_c = (r_count == '0);

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock controller: digit entry, code compare, timed unlock and failure lockout.
// Optional idle-entry timeout is compiled in with `define KEYPAD_TIMEOUT_EN.
module keypad_lock_ctrl
  import keypad_lock_pkg::*;
#(
  parameter int unsigned CODE_LEN       = 4,
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             digit_valid,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic                             submit,
  input  logic                             clear,
  input  logic [CODE_LEN*DIGIT_W-1:0]      stored_code,
  output logic                             unlock_led,
  output logic                             fail_led,
  output logic                             lockout_led,
  output logic                             ready_for_input,
  output logic [cnt_w(CODE_LEN)-1:0]       digit_count,
  output logic [cnt_w(MAX_FAILS)-1:0]      fail_count
);

  localparam int unsigned CODE_W  = CODE_LEN * DIGIT_W;
  localparam int unsigned CNT_W   = cnt_w(CODE_LEN);
  localparam int unsigned FAIL_W  = cnt_w(MAX_FAILS);
  localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TMR_W   = cnt_w(TMR_MAX);

  state_e            r_state, w_state_nxt;
  logic [CODE_W-1:0] r_buf, w_buf_nxt;
  logic [CNT_W-1:0]  r_digit_cnt, w_digit_cnt_nxt;
  logic [FAIL_W-1:0] r_fail_cnt, w_fail_cnt_nxt;
  logic              w_fail_pulse;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_load_val;
  logic              w_tmr_en;
  logic              w_tmr_expired;
  logic              r_unlock_led, r_fail_led, r_lockout_led, r_ready;

  // One timer serves both UNLOCKED and LOCKOUT since they never overlap.
  assign w_tmr_en = (r_state != ST_ENTRY);

  lock_timer #(.MAX_VAL(TMR_MAX)) u_state_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_tmr_load),
    .i_load_val  (w_tmr_load_val),
    .i_en        (w_tmr_en),
    .o_expired_c (w_tmr_expired)
  );

`ifdef KEYPAD_TIMEOUT_EN
  localparam int unsigned TO_W = cnt_w(TIMEOUT_CYCLES);

  logic w_to_restart, w_to_en, w_to_expired;

  assign w_to_restart = (r_state == ST_ENTRY) && digit_valid && !clear && !submit;
  assign w_to_en      = (r_state == ST_ENTRY) && (r_digit_cnt != '0);

  lock_timer #(.MAX_VAL(TIMEOUT_CYCLES)) u_entry_timeout (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_to_restart),
    .i_load_val  (TO_W'(TIMEOUT_CYCLES - 1)),
    .i_en        (w_to_en),
    .o_expired_c (w_to_expired)
  );
`else
  // Timeout disabled; the parameter is kept so both builds share one interface.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Next-state, entry buffer and failure bookkeeping.
  always_comb begin
    w_state_nxt     = r_state;
    w_buf_nxt       = r_buf;
    w_digit_cnt_nxt = r_digit_cnt;
    w_fail_cnt_nxt  = r_fail_cnt;
    w_fail_pulse    = 1'b0;
    w_tmr_load      = 1'b0;
    w_tmr_load_val  = '0;

    unique case (r_state)
      ST_ENTRY: begin
        if (clear) begin
          w_buf_nxt       = '0;
          w_digit_cnt_nxt = '0;
        end else if (submit) begin
          w_buf_nxt       = '0;
          w_digit_cnt_nxt = '0;
          if ((r_digit_cnt == CNT_W'(CODE_LEN)) && (r_buf == stored_code)) begin
            w_state_nxt    = ST_UNLOCKED;
            w_fail_cnt_nxt = '0;
            w_tmr_load     = 1'b1;
            w_tmr_load_val = TMR_W'(UNLOCK_CYCLES - 1);
          end else begin
            w_fail_pulse   = 1'b1;
            w_fail_cnt_nxt = r_fail_cnt + FAIL_W'(1);
            if (w_fail_cnt_nxt == FAIL_W'(MAX_FAILS)) begin
              w_state_nxt    = ST_LOCKOUT;
              w_tmr_load     = 1'b1;
              w_tmr_load_val = TMR_W'(LOCKOUT_CYCLES - 1);
            end
          end
        end else if (digit_valid) begin
          if (r_digit_cnt != CNT_W'(CODE_LEN)) begin
            w_buf_nxt       = (r_buf << DIGIT_W) | CODE_W'(digit_in);
            w_digit_cnt_nxt = r_digit_cnt + CNT_W'(1);
          end
`ifdef KEYPAD_TIMEOUT_EN
        end else if ((r_digit_cnt != '0) && w_to_expired) begin
          w_buf_nxt       = '0;
          w_digit_cnt_nxt = '0;
`endif
        end
      end
      ST_UNLOCKED: begin
        if (w_tmr_expired) begin
          w_state_nxt = ST_ENTRY;
        end
      end
      ST_LOCKOUT: begin
        if (w_tmr_expired) begin
          w_state_nxt    = ST_ENTRY;
          w_fail_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_ENTRY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_ENTRY;
      r_buf         <= '0;
      r_digit_cnt   <= '0;
      r_fail_cnt    <= '0;
      r_unlock_led  <= 1'b0;
      r_fail_led    <= 1'b0;
      r_lockout_led <= 1'b0;
      r_ready       <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_buf         <= w_buf_nxt;
      r_digit_cnt   <= w_digit_cnt_nxt;
      r_fail_cnt    <= w_fail_cnt_nxt;
      r_unlock_led  <= (w_state_nxt == ST_UNLOCKED);
      r_fail_led    <= w_fail_pulse;
      r_lockout_led <= (w_state_nxt == ST_LOCKOUT);
      r_ready       <= (w_state_nxt == ST_ENTRY);
    end
  end

  assign unlock_led      = r_unlock_led;
  assign fail_led        = r_fail_led;
  assign lockout_led     = r_lockout_led;
  assign ready_for_input = r_ready;
  assign digit_count     = r_digit_cnt;
  assign fail_count      = r_fail_cnt;

endmodule
